// File: rtl/matrix_ops_pkg.sv
// Shared definitions for the matrix_ops block family.
//  - clog2: constant-foldable ceiling log2, used to size counters and indices
//  - ST_IDLE / ST_MAC / ST_DONE: FSM state encodings
//  - elem_lsb: LSB position of element (row, col) in a row-major flat bus
package matrix_ops_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Row-major element slicing shared by all flat-bus matrix blocks.
    function automatic int elem_lsb(input int row, input int col,
                                    input int cols, input int elem_width);
        return (row * cols + col) * elem_width;
    endfunction

endpackage

// File: rtl/matrix_mac_lane.sv
// One multiply-accumulate lane of the matrix x vector engine.
// Ports:
//  clk, rst_n  clock and asynchronous active-low reset
//  clr         clear the accumulator (start of a new operation)
//  en          accumulate a*b this cycle
//  last        this is the final column of the row: sum/ovf are the row
//              result, and the accumulator is cleared for the next row
//  a, b        matrix and vector operands (DATA_WIDTH each)
//  sum         running total including this cycle's product, after
//              saturate/wrap to OUT_WIDTH
//  ovf         running total lies outside the OUT_WIDTH result range
module matrix_mac_lane
    import matrix_ops_pkg::*;
#(
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 1,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [OUT_WIDTH-1:0]  sum,
    output logic                  ovf
);

    // Range checks are done one bit wider than both the accumulator and the
    // output so the bounds and the sum are all representable as signed.
    localparam int CMP_W = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
    localparam logic [CMP_W-1:0] ONE   = 1;
    localparam logic [CMP_W-1:0] MAX_V = (SIGNED != 0) ? (ONE << (OUT_WIDTH - 1)) - ONE
                                                       : (ONE << OUT_WIDTH) - ONE;
    // -2^(OUT-1) is the bitwise complement of 2^(OUT-1)-1.
    localparam logic [CMP_W-1:0] MIN_V = (SIGNED != 0) ? ~MAX_V : '0;

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CMP_W-1:0]     sum_ext;
    logic                 a_sign;
    logic                 b_sign;
    logic                 s_sign;
    logic                 too_big;
    logic                 too_small;

    always_comb begin
        a_sign   = (SIGNED != 0) & a[DATA_WIDTH-1];
        b_sign   = (SIGNED != 0) & b[DATA_WIDTH-1];
        a_ext    = {{(ACC_WIDTH - DATA_WIDTH){a_sign}}, a};
        b_ext    = {{(ACC_WIDTH - DATA_WIDTH){b_sign}}, b};
        // Modulo-2^ACC_WIDTH product of the extended operands equals the
        // exact 2*DATA_WIDTH product, extended to ACC_WIDTH.
        prod     = a_ext * b_ext;
        acc_next = acc_reg + prod;
        s_sign   = (SIGNED != 0) & acc_next[ACC_WIDTH-1];
        sum_ext  = {{(CMP_W - ACC_WIDTH){s_sign}}, acc_next};

        too_big   = $signed(sum_ext) > $signed(MAX_V);
        too_small = $signed(sum_ext) < $signed(MIN_V);
        ovf       = too_big | too_small;

        sum = sum_ext[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (too_big) begin
                sum = MAX_V[OUT_WIDTH-1:0];
            end else if (too_small) begin
                sum = MIN_V[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= last ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/matrix_vector_mac_engine.sv
// Sequential matrix x vector multiplier: result = M(HxW) * v(W), computed
// LANES rows at a time, one column per clock.
// Ports:
//  clk         rising-edge clock
//  i_rst_n     asynchronous active-low reset
//  i_calc      start request (accepted in IDLE or DONE)
//  i_matrix    H*W elements, (r,c) at [(r*W+c)*DATA_WIDTH +: DATA_WIDTH]
//  i_vector    W elements, c at [c*DATA_WIDTH +: DATA_WIDTH]
//  o_result    H results, row r at [r*OUT_WIDTH +: OUT_WIDTH]
//  o_ready     result valid (DONE state)
//  o_busy      computation in progress (MAC state)
//  o_overflow  some row of the last operation saturated or wrapped
module matrix_vector_mac_engine
    import matrix_ops_pkg::*;
#(
    parameter int MATRIX_WIDTH  = 2,
    parameter int MATRIX_HEIGHT = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int OUT_WIDTH     = 8,
    parameter int LANES         = 1,
    parameter int SIGNED        = 0,
    parameter int SATURATE      = 1
) (
    input  logic                                         clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_calc,
    input  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] i_matrix,
    input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]           i_vector,
    output logic [MATRIX_HEIGHT*OUT_WIDTH-1:0]           o_result,
    output logic                                         o_ready,
    output logic                                         o_busy,
    output logic                                         o_overflow
);

    // One spare bit on top of the full W-term sum so signed totals never wrap.
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + clog2(MATRIX_WIDTH) + 1;
    localparam int GROUPS    = MATRIX_HEIGHT / LANES;
    localparam int M_BITS    = MATRIX_HEIGHT * MATRIX_WIDTH * DATA_WIDTH;
    localparam int V_BITS    = MATRIX_WIDTH * DATA_WIDTH;
    localparam int R_BITS    = MATRIX_HEIGHT * OUT_WIDTH;
    localparam int COL_W     = (MATRIX_WIDTH > 1) ? clog2(MATRIX_WIDTH) : 1;
    localparam int GRP_W     = (GROUPS > 1) ? clog2(GROUPS) : 1;
    localparam int MIDX_W    = (M_BITS > 1) ? clog2(M_BITS) : 1;
    localparam int VIDX_W    = (V_BITS > 1) ? clog2(V_BITS) : 1;
    localparam int RIDX_W    = (R_BITS > 1) ? clog2(R_BITS) : 1;

    generate
        if (MATRIX_HEIGHT % LANES != 0) begin : g_bad_lanes
            $error("matrix_vector_mac_engine: LANES must divide MATRIX_HEIGHT");
        end
    endgenerate

    logic [1:0]             state_reg;
    logic [COL_W-1:0]       col_reg;
    logic [GRP_W-1:0]       grp_reg;
    logic [M_BITS-1:0]      matrix_reg;
    logic [V_BITS-1:0]      vector_reg;
    logic [R_BITS-1:0]      result_reg;
    logic                   overflow_reg;

    logic                   accept;
    logic                   mac_en;
    logic                   last_col;
    logic                   last_grp;
    logic                   any_ovf;
    logic [VIDX_W-1:0]      b_idx;
    logic [DATA_WIDTH-1:0]  b_op;
    logic [OUT_WIDTH-1:0]   lane_sum [LANES];
    logic                   lane_ovf [LANES];

    always_comb begin
        accept   = i_calc && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
        mac_en   = (state_reg == ST_MAC);
        last_col = (col_reg == COL_W'(MATRIX_WIDTH - 1));
        last_grp = (grp_reg == GRP_W'(GROUPS - 1));
        // Every lane works on the same column, so the vector element is shared.
        b_idx    = VIDX_W'(int'(col_reg) * DATA_WIDTH);
        b_op     = vector_reg[b_idx +: DATA_WIDTH];
        any_ovf  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            any_ovf = any_ovf | lane_ovf[l];
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [MIDX_W-1:0]     a_idx;
            logic [DATA_WIDTH-1:0] a_op;

            // Lane gi handles row grp*LANES+gi of the current group.
            always_comb begin
                a_idx = MIDX_W'(elem_lsb(int'(grp_reg) * LANES + gi, int'(col_reg),
                                         MATRIX_WIDTH, DATA_WIDTH));
                a_op  = matrix_reg[a_idx +: DATA_WIDTH];
            end

            matrix_mac_lane #(
                .SIGNED     (SIGNED),
                .SATURATE   (SATURATE),
                .DATA_WIDTH (DATA_WIDTH),
                .OUT_WIDTH  (OUT_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (i_rst_n),
                .clr   (accept),
                .en    (mac_en),
                .last  (last_col),
                .a     (a_op),
                .b     (b_op),
                .sum   (lane_sum[gi]),
                .ovf   (lane_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            col_reg      <= '0;
            grp_reg      <= '0;
            matrix_reg   <= '0;
            vector_reg   <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (i_calc) begin
                        matrix_reg   <= i_matrix;
                        vector_reg   <= i_vector;
                        overflow_reg <= 1'b0;
                        col_reg      <= '0;
                        grp_reg      <= '0;
                        state_reg    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last_col) begin
                        col_reg      <= '0;
                        overflow_reg <= overflow_reg | any_ovf;
                        for (int l = 0; l < LANES; l++) begin
                            result_reg[RIDX_W'((int'(grp_reg) * LANES + l) * OUT_WIDTH) +: OUT_WIDTH]
                                <= lane_sum[l];
                        end
                        if (last_grp) begin
                            grp_reg   <= '0;
                            state_reg <= ST_DONE;
                        end else begin
                            grp_reg <= grp_reg + 1'b1;
                        end
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_result   = result_reg;
    assign o_overflow = overflow_reg;
    assign o_ready    = (state_reg == ST_DONE);
    assign o_busy     = (state_reg == ST_MAC);

endmodule

// File: tb/tb_matrix_vector_mac_engine.sv
module tb_matrix_vector_mac_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] mat [4];
    logic [23:0] vec [4];
    logic        calc [4];
    logic [63:0] res_w [4];
    logic        ready_w [4];
    logic        busy_w [4];
    logic        ovf_w [4];

    int checks = 0;
    int errors = 0;

    initial forever #5 clk = ~clk;

    // Four configurations: 0 unsigned/saturate, 1 unsigned/wrap,
    // 2 signed OUT=16, 3 H=4 W=3 LANES=2.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
            localparam int H   = (gi == 3) ? 4 : 2;
            localparam int W   = (gi == 3) ? 3 : 2;
            localparam int L   = (gi == 3) ? 2 : 1;
            localparam int DW  = 8;
            localparam int OW  = (gi == 2) ? 16 : 8;
            localparam int S   = (gi == 2) ? 1 : 0;
            localparam int SAT = (gi == 1) ? 0 : 1;
            localparam int N   = W * H / L;

            logic [H*OW-1:0] res;

            matrix_vector_mac_engine #(
                .MATRIX_WIDTH (W), .MATRIX_HEIGHT (H), .DATA_WIDTH (DW),
                .OUT_WIDTH (OW), .LANES (L), .SIGNED (S), .SATURATE (SAT)
            ) dut (
                .clk        (clk),
                .i_rst_n    (rst_n),
                .i_calc     (calc[gi]),
                .i_matrix   (mat[gi][H*W*DW-1:0]),
                .i_vector   (vec[gi][W*DW-1:0]),
                .o_result   (res),
                .o_ready    (ready_w[gi]),
                .o_busy     (busy_w[gi]),
                .o_overflow (ovf_w[gi])
            );

            assign res_w[gi] = 64'(res);

            // Plain-arithmetic reference: {overflow, results}.
            function automatic logic [H*OW:0] model(input logic [H*W*DW-1:0] m,
                                                    input logic [W*DW-1:0] v);
                logic [H*OW:0] out;
                longint s, a, b, lo, hi, r;
                out = '0;
                lo  = (S != 0) ? -(longint'(1) <<< (OW - 1)) : 0;
                hi  = (S != 0) ? (longint'(1) <<< (OW - 1)) - 1 : (longint'(1) <<< OW) - 1;
                for (int ri = 0; ri < H; ri++) begin
                    s = 0;
                    for (int c = 0; c < W; c++) begin
                        a = longint'(m[(ri*W+c)*DW +: DW]);
                        b = longint'(v[c*DW +: DW]);
                        if (S != 0 && a >= (longint'(1) <<< (DW - 1))) a = a - (longint'(1) <<< DW);
                        if (S != 0 && b >= (longint'(1) <<< (DW - 1))) b = b - (longint'(1) <<< DW);
                        s = s + a * b;
                    end
                    r = s;
                    if (s > hi) begin
                        out[H*OW] = 1'b1;
                        if (SAT != 0) r = hi;
                    end else if (s < lo) begin
                        out[H*OW] = 1'b1;
                        if (SAT != 0) r = lo;
                    end
                    out[ri*OW +: OW] = r[OW-1:0];
                end
                return out;
            endfunction

            // Transaction-level expectation: an accepted request completes N
            // edges later; results are meaningful outside of a computation.
            int              m_cnt;
            logic            m_ready;
            logic            m_show;
            logic [H*OW-1:0] m_res;
            logic [H*OW-1:0] m_pend;
            logic            m_ovf;
            logic            m_povf;

            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_cnt   <= 0;
                    m_ready <= 1'b0;
                    m_show  <= 1'b1;
                    m_res   <= '0;
                    m_ovf   <= 1'b0;
                    m_pend  <= '0;
                    m_povf  <= 1'b0;
                end else if (m_cnt > 0) begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_ready <= 1'b1;
                        m_show  <= 1'b1;
                        m_res   <= m_pend;
                        m_ovf   <= m_povf;
                    end
                end else if (calc[gi]) begin
                    {m_povf, m_pend} <= model(mat[gi][H*W*DW-1:0], vec[gi][W*DW-1:0]);
                    m_cnt   <= N;
                    m_ready <= 1'b0;
                    m_show  <= 1'b0;
                end
            end
        end
    endgenerate

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_inst(input int g, input logic rdy, input logic mrdy,
                            input logic bsy, input logic mbsy, input logic show,
                            input logic [63:0] r, input logic [63:0] mr,
                            input logic o, input logic mo);
        check($sformatf("g%0d ready", g), 64'(rdy), 64'(mrdy));
        check($sformatf("g%0d busy", g), 64'(bsy), 64'(mbsy));
        if (show) begin
            check($sformatf("g%0d result", g), r, mr);
            check($sformatf("g%0d overflow", g), 64'(o), 64'(mo));
        end
    endtask

    task automatic compare_all();
        cmp_inst(0, ready_w[0], g_cfg[0].m_ready, busy_w[0], g_cfg[0].m_cnt != 0, g_cfg[0].m_show,
                 res_w[0], 64'(g_cfg[0].m_res), ovf_w[0], g_cfg[0].m_ovf);
        cmp_inst(1, ready_w[1], g_cfg[1].m_ready, busy_w[1], g_cfg[1].m_cnt != 0, g_cfg[1].m_show,
                 res_w[1], 64'(g_cfg[1].m_res), ovf_w[1], g_cfg[1].m_ovf);
        cmp_inst(2, ready_w[2], g_cfg[2].m_ready, busy_w[2], g_cfg[2].m_cnt != 0, g_cfg[2].m_show,
                 res_w[2], 64'(g_cfg[2].m_res), ovf_w[2], g_cfg[2].m_ovf);
        cmp_inst(3, ready_w[3], g_cfg[3].m_ready, busy_w[3], g_cfg[3].m_cnt != 0, g_cfg[3].m_show,
                 res_w[3], 64'(g_cfg[3].m_res), ovf_w[3], g_cfg[3].m_ovf);
    endtask

    // Issue one request, scramble the inputs right after acceptance, and
    // count edges until o_ready (bounded) and cycles with o_busy high.
    task automatic do_op(input int g, input logic [95:0] m, input logic [23:0] v,
                         output int lat, output int bcnt);
        @(negedge clk);
        mat[g]  = m;
        vec[g]  = v;
        calc[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calc[g] = 1'b0;
        mat[g]  = {$urandom, $urandom, $urandom};
        vec[g]  = 24'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!ready_w[g] && lat < 50) begin
            if (busy_w[g]) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op g%0d: latency %0d busy %0d result %0h overflow %0b",
                 g, lat, bcnt, res_w[g], ovf_w[g]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, got;
        longint prev;
        logic [95:0] idm;

        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            calc[g] = 1'b0;
            mat[g]  = '0;
            vec[g]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("reset g%0d result", g), res_w[g], 64'h0);
            check($sformatf("reset g%0d ready", g), 64'(ready_w[g]), 64'h0);
            check($sformatf("reset g%0d busy", g), 64'(busy_w[g]), 64'h0);
            check($sformatf("reset g%0d overflow", g), 64'(ovf_w[g]), 64'h0);
        end
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        // Case 1: unsigned saturating, row0 = 256 clamps to 255.
        do_op(0, 96'h02_03_06_0E, 24'h0A_0E, lat, bcnt);
        check("case1 latency", 64'(lat), 64'd4);
        check("case1 result", res_w[0], 64'h3EFF);
        check("case1 overflow", 64'(ovf_w[0]), 64'h1);

        // Case 2: same stimulus, wrapping.
        do_op(1, 96'h02_03_06_0E, 24'h0A_0E, lat, bcnt);
        check("case2 result", res_w[1], 64'h3E00);
        check("case2 overflow", 64'(ovf_w[1]), 64'h1);

        // Case 3: signed, 16-bit results.
        do_op(2, 96'h7F_80_02_FF, 24'hFC_03, lat, bcnt);
        check("case3 latency", 64'(lat), 64'd4);
        check("case3 result", res_w[2], 64'hFC84_FFF5);
        check("case3 overflow", 64'(ovf_w[2]), 64'h0);

        // Case 4: 4x3 identity-padded matrix, two lanes.
        idm = '0;
        for (int r = 0; r < 3; r++) idm[(r*3+r)*8 +: 8] = 8'd1;
        do_op(3, idm, 24'h07_06_05, lat, bcnt);
        check("case4 latency", 64'(lat), 64'd6);
        check("case4 busy cycles", 64'(bcnt), 64'd6);
        check("case4 result", res_w[3], 64'h00_07_06_05);

        // Case 5: reset during the second MAC cycle.
        @(negedge clk);
        mat[0]  = 96'h02_03_06_0E;
        vec[0]  = 24'h0A_0E;
        calc[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calc[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("case5 async result", res_w[0], 64'h0);
        check("case5 async ready", 64'(ready_w[0]), 64'h0);
        check("case5 async busy", 64'(busy_w[0]), 64'h0);
        check("case5 async overflow", 64'(ovf_w[0]), 64'h0);
        check("case5 async g3 result", res_w[3], 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(0, 96'h02_03_06_0E, 24'h0A_0E, lat, bcnt);
        check("case5 rerun latency", 64'(lat), 64'd4);
        check("case5 rerun result", res_w[0], 64'h3EFF);

        // Case 6: i_calc held high, fresh inputs on every DONE cycle.
        @(negedge clk);
        mat[0]  = {64'h0, 32'hFF80_40C0};
        vec[0]  = 24'h00_FFFF;
        calc[0] = 1'b1;
        got  = 0;
        prev = 0;
        for (int i = 0; i < 60 && got < 5; i++) begin
            @(negedge clk);
            if (ready_w[0]) begin
                $display("b2b op %0d: result %0h overflow %0b", got, res_w[0], ovf_w[0]);
                if (got > 0) check("case6 ready period", 64'(($time - prev) / 10), 64'd5);
                prev = $time;
                got++;
                mat[0] = {64'h0, $urandom};
                vec[0] = 24'($urandom);
            end
        end
        check("case6 pulses seen", 64'(got), 64'd5);
        calc[0] = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
